issue_stage: RTL and testbench

- Parametrised decode-to-execute issue register. It replaces fixed stall counters with a per-register scoreboard, valid/ready handshakes and a configurable control-hazard shadow.
- Sits between the control/register-file read and the ALU/MUL/DIV/memory execute stage.
- Takes already-decoded fields plus register read data, and issues one instruction per cycle when it is hazard-free.

---
 rtl/issue_pkg.sv | 30 +++
 rtl/issue_if.sv | 56 +++++
 rtl/issue_scoreboard.sv | 51 +++++
 rtl/issue_stage.sv | 185 ++++++++++++++++++
 tb/tb_issue_stage.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_pkg.sv
// Shared types and helpers for the decode-to-execute issue stage.
package issue_pkg;

  // Register index width for a given architectural register count.
  function automatic int reg_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int CTRL_W_DEF = 24;
  localparam int REG_AW_DEF = reg_aw(NREGS_DEF);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_CTRL = 1'b1
  } state_t;

  // Contents of the issue register at the default configuration.
  typedef struct packed {
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [XLEN_DEF-1:0]   pc;
    logic [XLEN_DEF-1:0]   imm;
    logic [XLEN_DEF-1:0]   a;
    logic [XLEN_DEF-1:0]   b;
    logic [REG_AW_DEF-1:0] rd;
    logic                  reg_we;
  } issue_t;

endpackage

// File: rtl/issue_if.sv
// Decode-side request channel and execute-side issue channel of the issue stage.
interface issue_if
  import issue_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int CTRL_W = 24,
  parameter int REG_AW = reg_aw(NREGS)
);

  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [REG_AW-1:0] in_rd;
  logic              in_use_rs1;
  logic              in_use_rs2;
  logic              in_reg_we;
  logic              in_is_load;
  logic              in_is_ctrl;
  logic              in_is_long;
  logic [CTRL_W-1:0] in_ctrl;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_imm;
  logic [XLEN-1:0]   in_rdata_a;
  logic [XLEN-1:0]   in_rdata_b;

  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_imm;
  logic [XLEN-1:0]   out_a;
  logic [XLEN-1:0]   out_b;
  logic [REG_AW-1:0] out_rd;
  logic              out_reg_we;

  // Surrounding pipeline: supplies decoded instructions, consumes issued ones.
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_reg_we,
           in_is_load, in_is_ctrl, in_is_long, in_ctrl, in_pc, in_imm,
           in_rdata_a, in_rdata_b, out_ready,
    input  in_ready, out_valid, out_ctrl, out_pc, out_imm, out_a, out_b,
           out_rd, out_reg_we
  );

  // Issue stage.
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_reg_we,
           in_is_load, in_is_ctrl, in_is_long, in_ctrl, in_pc, in_imm,
           in_rdata_a, in_rdata_b, out_ready,
    output in_ready, out_valid, out_ctrl, out_pc, out_imm, out_a, out_b,
           out_rd, out_reg_we
  );

endinterface

// File: rtl/issue_scoreboard.sv
// Per-register busy tracking for loads and long ops, with source hazard lookup.
module issue_scoreboard #(
  parameter int NREGS  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_rd,
  input  logic              use_rs1,
  input  logic [REG_AW-1:0] rs1,
  input  logic              use_rs2,
  input  logic [REG_AW-1:0] rs2,
  output logic              haz_rs1,
  output logic              haz_rs2,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] busy_nxt;

  // Next busy vector: an issuing producer beats a same-index writeback; x0 is never busy.
  always_comb begin
    busy_nxt = busy;
    for (int i = 1; i < NREGS; i++) begin
      if (set_en && (set_rd == REG_AW'(i))) begin
        busy_nxt[i] = 1'b1;
      end else if (clr_en && (clr_rd == REG_AW'(i))) begin
        busy_nxt[i] = 1'b0;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // A source stalls only while its producer is busy and not writing back this cycle.
  always_comb begin
    haz_rs1 = use_rs1 && busy[rs1] && !(clr_en && (clr_rd == rs1));
    haz_rs2 = use_rs2 && busy[rs2] && !(clr_en && (clr_rd == rs2));
  end

endmodule

// File: rtl/issue_stage.sv
// Decode-to-execute issue register with scoreboard, bypass and control-hazard shadow.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_RUN  | normal issue, gated only by data and long-op hazards
//   S_CTRL | shadow after a branch/jump issued; cnt counts remaining cycles
module issue_stage
  import issue_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NREGS          = 32,
  parameter int CTRL_W         = 24,
  parameter int CTRL_BUBBLES   = 3,
  parameter bit SERIALIZE_LONG = 1'b1,
  parameter int REG_AW         = reg_aw(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              flush,
  issue_if.slave            io,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              long_done,
  output logic [NREGS-1:0]  busy
);

  localparam int CNT_W = (CTRL_BUBBLES > 0) ? $clog2(CTRL_BUBBLES + 1) : 1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [REG_AW-1:0] rd;
    logic              reg_we;
  } stage_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ctrl_block;
  logic             long_pending;
  logic             hazard;
  logic             accept;
  logic             haz_rs1;
  logic             haz_rs2;
  logic             sb_set;
  logic             out_valid_q;
  stage_t           out_q;
  stage_t           out_d;

  // Only loads and long ops leave a result in flight past the execute stage.
  assign sb_set = accept && io.in_reg_we && (io.in_is_load || io.in_is_long);

  issue_scoreboard #(
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (sb_set),
    .set_rd  (io.in_rd),
    .clr_en  (wb_we),
    .clr_rd  (wb_rd),
    .use_rs1 (io.in_use_rs1),
    .rs1     (io.in_rs1),
    .use_rs2 (io.in_use_rs2),
    .rs2     (io.in_rs2),
    .haz_rs1 (haz_rs1),
    .haz_rs2 (haz_rs2),
    .busy    (busy)
  );

  // Issue is blocked by data hazards, the control shadow, or an outstanding long op.
  always_comb begin
    hazard = haz_rs1 || haz_rs2 || ctrl_block
          || (io.in_is_long && long_pending)
          || (SERIALIZE_LONG && long_pending);
  end

  assign io.in_ready = run && !flush && !hazard && (!out_valid_q || io.out_ready);
  assign accept      = io.in_valid && io.in_ready;

  // Capture payload, taking operands from the writeback bus when it targets a source.
  always_comb begin
    out_d        = '0;
    out_d.ctrl   = io.in_ctrl;
    out_d.pc     = io.in_pc;
    out_d.imm    = io.in_imm;
    out_d.a      = (wb_we && (wb_rd == io.in_rs1) && (io.in_rs1 != '0)) ? wb_data : io.in_rdata_a;
    out_d.b      = (wb_we && (wb_rd == io.in_rs2) && (io.in_rs2 != '0)) ? wb_data : io.in_rdata_b;
    out_d.rd     = io.in_rd;
    out_d.reg_we = io.in_reg_we;
  end

  // Issue register: flush kills the held instruction, run=0 freezes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (run) begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_q       <= out_d;
      end else if (out_valid_q && io.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign io.out_valid  = out_valid_q;
  assign io.out_ctrl   = out_q.ctrl;
  assign io.out_pc     = out_q.pc;
  assign io.out_imm    = out_q.imm;
  assign io.out_a      = out_q.a;
  assign io.out_b      = out_q.b;
  assign io.out_rd     = out_q.rd;
  assign io.out_reg_we = out_q.reg_we;

  // Long-op tracker; a new long op issuing beats a completion in the same cycle.
  // Survives flush and run=0 because the op is already executing.
  always_ff @(posedge clk) begin
    if (reset) begin
      long_pending <= 1'b0;
    end else if (accept && io.in_is_long) begin
      long_pending <= 1'b1;
    end else if (long_done) begin
      long_pending <= 1'b0;
    end
  end

  // FSM state and shadow down-counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: enter the shadow on control issue, leave at terminal count or on flush.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_RUN: begin
        if ((CTRL_BUBBLES > 0) && accept && io.in_is_ctrl) begin
          state_nxt = S_CTRL;
          cnt_nxt   = CNT_W'(CTRL_BUBBLES);
        end
      end
      S_CTRL: begin
        if (flush) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else if (run) begin
          if (cnt == CNT_W'(1)) begin
            state_nxt = S_RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = S_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM output: the whole shadow blocks issue.
  always_comb begin
    ctrl_block = (state == S_CTRL);
  end

endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: directed scenarios followed by random traffic
// compared against a cycle-level behavioural model.
module tb_issue_stage;
  import issue_pkg::*;

  localparam int CB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, flush, long_done;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        in_valid, in_use_rs1, in_use_rs2, in_reg_we, in_is_load, in_is_ctrl, in_is_long;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [23:0] in_ctrl;
  logic [31:0] in_pc, in_imm, in_rdata_a, in_rdata_b;
  logic        out_ready;
  logic [31:0] busy0, busy1;

  issue_if #(.XLEN(32), .NREGS(32), .CTRL_W(24)) bif0 ();
  issue_if #(.XLEN(32), .NREGS(32), .CTRL_W(24)) bif1 ();

  // Both instances see identical stimulus; they differ only in SERIALIZE_LONG.
  assign bif0.in_valid = in_valid;     assign bif1.in_valid = in_valid;
  assign bif0.in_rs1 = in_rs1;         assign bif1.in_rs1 = in_rs1;
  assign bif0.in_rs2 = in_rs2;         assign bif1.in_rs2 = in_rs2;
  assign bif0.in_rd = in_rd;           assign bif1.in_rd = in_rd;
  assign bif0.in_use_rs1 = in_use_rs1; assign bif1.in_use_rs1 = in_use_rs1;
  assign bif0.in_use_rs2 = in_use_rs2; assign bif1.in_use_rs2 = in_use_rs2;
  assign bif0.in_reg_we = in_reg_we;   assign bif1.in_reg_we = in_reg_we;
  assign bif0.in_is_load = in_is_load; assign bif1.in_is_load = in_is_load;
  assign bif0.in_is_ctrl = in_is_ctrl; assign bif1.in_is_ctrl = in_is_ctrl;
  assign bif0.in_is_long = in_is_long; assign bif1.in_is_long = in_is_long;
  assign bif0.in_ctrl = in_ctrl;       assign bif1.in_ctrl = in_ctrl;
  assign bif0.in_pc = in_pc;           assign bif1.in_pc = in_pc;
  assign bif0.in_imm = in_imm;         assign bif1.in_imm = in_imm;
  assign bif0.in_rdata_a = in_rdata_a; assign bif1.in_rdata_a = in_rdata_a;
  assign bif0.in_rdata_b = in_rdata_b; assign bif1.in_rdata_b = in_rdata_b;
  assign bif0.out_ready = out_ready;   assign bif1.out_ready = out_ready;

  issue_stage #(.XLEN(32), .NREGS(32), .CTRL_W(24), .CTRL_BUBBLES(CB), .SERIALIZE_LONG(1'b0)) dut0 (
    .clk(clk), .reset(reset), .run(run), .flush(flush), .io(bif0),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .long_done(long_done), .busy(busy0)
  );

  issue_stage #(.XLEN(32), .NREGS(32), .CTRL_W(24), .CTRL_BUBBLES(CB), .SERIALIZE_LONG(1'b1)) dut1 (
    .clk(clk), .reset(reset), .run(run), .flush(flush), .io(bif1),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .long_done(long_done), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;
  logic rdy0, rdy1;

  // Reference model of dut0 (no long-op serialisation).
  logic [31:0] m_busy;
  bit          m_lp;
  int          m_shadow;
  bit          m_ov;
  issue_t      m_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit src_blocked(input bit use_src, input logic [4:0] rs);
    return use_src && m_busy[rs] && !(wb_we && wb_rd == rs);
  endfunction

  function automatic bit model_ready();
    bit haz;
    haz = src_blocked(in_use_rs1, in_rs1) || src_blocked(in_use_rs2, in_rs2)
       || (m_shadow > 0) || (in_is_long && m_lp);
    return run && !flush && !haz && (!m_ov || out_ready);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
    return (wb_we && wb_rd == rs && rs != 5'd0) ? wb_data : rf;
  endfunction

  task automatic model_edge(input bit acc);
    if (reset) begin
      m_busy = '0; m_lp = 0; m_shadow = 0; m_ov = 0; m_out = '0;
      return;
    end
    if (flush) m_ov = 0;
    else if (run) begin
      if (acc) begin
        m_ov = 1;
        m_out.ctrl = in_ctrl; m_out.pc = in_pc; m_out.imm = in_imm;
        m_out.a = operand(in_rs1, in_rdata_a);
        m_out.b = operand(in_rs2, in_rdata_b);
        m_out.rd = in_rd; m_out.reg_we = in_reg_we;
      end else if (m_ov && out_ready) m_ov = 0;
    end
    if (wb_we) m_busy[wb_rd] = 1'b0;
    if (acc && in_reg_we && (in_is_load || in_is_long) && in_rd != 5'd0) m_busy[in_rd] = 1'b1;
    if (acc && in_is_long) m_lp = 1;
    else if (long_done) m_lp = 0;
    if (m_shadow > 0) begin
      if (flush) m_shadow = 0;
      else if (run) m_shadow--;
    end else if (acc && in_is_ctrl) m_shadow = CB;
  endtask

  // One clock: check ready mid-cycle, advance model, check registered state after the edge.
  task automatic step();
    bit exp_rdy, acc;
    @(negedge clk);
    rdy0 = bif0.in_ready;
    rdy1 = bif1.in_ready;
    exp_rdy = model_ready();
    if (!reset) chk("in_ready", 64'(rdy0), 64'(exp_rdy));
    acc = in_valid && exp_rdy;
    model_edge(acc);
    @(posedge clk);
    #1;
    chk("out_valid", 64'(bif0.out_valid), 64'(m_ov));
    chk("out_ctrl", 64'(bif0.out_ctrl), 64'(m_out.ctrl));
    chk("out_pc", 64'(bif0.out_pc), 64'(m_out.pc));
    chk("out_imm", 64'(bif0.out_imm), 64'(m_out.imm));
    chk("out_a", 64'(bif0.out_a), 64'(m_out.a));
    chk("out_b", 64'(bif0.out_b), 64'(m_out.b));
    chk("out_rd", 64'(bif0.out_rd), 64'(m_out.rd));
    chk("out_reg_we", 64'(bif0.out_reg_we), 64'(m_out.reg_we));
    chk("busy", 64'(busy0), 64'(m_busy));
  endtask

  task automatic idle();
    reset = 0; run = 1; flush = 0; out_ready = 1; long_done = 0;
    wb_we = 0; wb_rd = '0; wb_data = '0;
    in_valid = 0; in_use_rs1 = 0; in_use_rs2 = 0; in_reg_we = 0;
    in_is_load = 0; in_is_ctrl = 0; in_is_long = 0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_ctrl = '0; in_pc = '0; in_imm = '0; in_rdata_a = '0; in_rdata_b = '0;
  endtask

  task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input bit u1, input bit u2, input bit we, input bit ld, input bit ctl,
                       input bit lg);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_use_rs1 = u1; in_use_rs2 = u2; in_reg_we = we;
    in_is_load = ld; in_is_ctrl = ctl; in_is_long = lg;
    in_ctrl = 24'($urandom); in_pc = $urandom; in_imm = $urandom;
    in_rdata_a = $urandom; in_rdata_b = $urandom;
  endtask

  initial begin
    logic [31:0] pc_a, pc_b;
    bit ld, lg, ctl;
    m_busy = '0; m_lp = 0; m_shadow = 0; m_ov = 0; m_out = '0;
    idle();
    reset = 1;
    step();
    step();
    reset = 0;

    // Load-use stall released by writeback with bypass.
    instr(5'd1, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0);
    step();
    chk("load_busy5", 64'(busy0[5]), 64'd1);
    instr(5'd5, 5'd1, 5'd6, 1, 1, 1, 0, 0, 0);
    step();
    chk("raw_block", 64'(rdy0), 64'd0);
    step();
    chk("raw_block2", 64'(rdy0), 64'd0);
    wb_we = 1; wb_rd = 5'd5; wb_data = 32'h1234;
    step();
    chk("raw_release", 64'(rdy0), 64'd1);
    chk("bypass_a", 64'(bif0.out_a), 64'h1234);
    chk("bypass_rd", 64'(bif0.out_rd), 64'd6);
    wb_we = 0; in_valid = 0;
    step();

    // Control shadow of exactly CB cycles, then shortened by flush.
    instr(5'd0, 5'd0, 5'd1, 0, 0, 1, 0, 1, 0);
    step();
    chk("jal_issue", 64'(rdy0), 64'd1);
    instr(5'd2, 5'd3, 5'd4, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < CB; i++) begin
      step();
      chk("shadow_block", 64'(rdy0), 64'd0);
    end
    step();
    chk("shadow_end", 64'(rdy0), 64'd1);
    instr(5'd0, 5'd0, 5'd1, 0, 0, 1, 0, 1, 0);
    step();
    instr(5'd2, 5'd3, 5'd4, 1, 1, 1, 0, 0, 0);
    step();
    chk("shadow_first", 64'(rdy0), 64'd0);
    flush = 1;
    step();
    chk("flush_block", 64'(rdy0), 64'd0);
    flush = 0;
    step();
    chk("flush_release", 64'(rdy0), 64'd1);
    in_valid = 0;
    step();

    // Long op: independent add proceeds unless long ops serialise.
    instr(5'd0, 5'd0, 5'd7, 0, 0, 1, 0, 0, 1);
    step();
    chk("div_issue0", 64'(rdy0), 64'd1);
    chk("div_issue1", 64'(rdy1), 64'd1);
    instr(5'd2, 5'd3, 5'd8, 1, 1, 1, 0, 0, 0);
    step();
    chk("ser0_go", 64'(rdy0), 64'd1);
    chk("ser1_block", 64'(rdy1), 64'd0);
    in_valid = 0;
    in_is_long = 1;
    step();
    chk("long2_block", 64'(rdy0), 64'd0);
    in_is_long = 0;
    long_done = 1; wb_we = 1; wb_rd = 5'd7; wb_data = $urandom;
    step();
    chk("ser1_wait", 64'(rdy1), 64'd0);
    long_done = 0; wb_we = 0;
    step();
    chk("ser1_release", 64'(rdy1), 64'd1);

    // Output back-pressure holds the register and the next instruction.
    instr(5'd2, 5'd3, 5'd10, 1, 1, 1, 0, 0, 0);
    pc_a = in_pc;
    step();
    instr(5'd4, 5'd5, 5'd12, 1, 1, 1, 0, 0, 0);
    pc_b = in_pc;
    out_ready = 0;
    step();
    chk("hold_block", 64'(rdy0), 64'd0);
    chk("hold_pc", 64'(bif0.out_pc), 64'(pc_a));
    step();
    chk("hold_pc2", 64'(bif0.out_pc), 64'(pc_a));
    out_ready = 1;
    step();
    chk("hold_release", 64'(rdy0), 64'd1);
    chk("second_pc", 64'(bif0.out_pc), 64'(pc_b));
    in_valid = 0;
    step();
    chk("drain", 64'(bif0.out_valid), 64'd0);

    // Set beats clear on the same index; x0 never becomes busy.
    instr(5'd0, 5'd0, 5'd9, 0, 0, 1, 1, 0, 0);
    wb_we = 1; wb_rd = 5'd9; wb_data = $urandom;
    step();
    chk("set_wins", 64'(busy0[9]), 64'd1);
    chk("set_wins_ser", 64'(busy1[9]), 64'd1);
    wb_we = 0;
    instr(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0);
    step();
    chk("x0_never", 64'(busy0), 64'h200);
    in_valid = 0; wb_we = 1; wb_rd = 5'd9;
    step();
    wb_we = 0;

    // Reset in the control shadow with a long op outstanding.
    instr(5'd0, 5'd0, 5'd11, 0, 0, 1, 0, 0, 1);
    step();
    instr(5'd0, 5'd0, 5'd1, 0, 0, 1, 0, 1, 0);
    step();
    chk("pre_rst_busy", 64'(busy0[11]), 64'd1);
    in_valid = 0;
    reset = 1;
    step();
    chk("rst_out_valid", 64'(bif0.out_valid), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    reset = 0;
    step();
    chk("rst_ready", 64'(rdy0), 64'd1);
    chk("rst_ready_ser", 64'(rdy1), 64'd1);

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 800; n++) begin
      ld  = ($urandom_range(0, 3) == 0);
      lg  = !ld && ($urandom_range(0, 9) == 0);
      ctl = !ld && !lg && ($urandom_range(0, 9) == 0);
      instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
            ld, ctl, lg);
      in_valid  = ($urandom_range(0, 3) != 0);
      run       = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      wb_we     = ($urandom_range(0, 2) == 0);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      long_done = ($urandom_range(0, 5) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
